// File: rtl/req_arbiter_12.sv
// ----------------------------------------------------------------------------
// req_arbiter_12
// Shares one resource among 12 requesters. Each cycle in IDLE the request
// vector is arbitrated, either fixed priority (bit 11 highest) or round-robin
// (search starts one below the last winner and walks downward with wrap). The
// winner keeps a registered one-hot grant until it signals done, drops its
// request, or reaches MAX_HOLD consecutive grant cycles. A timeout-forced
// revoke produces a one-cycle timeout pulse in the following IDLE cycle.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_req       request vector, bit i = requester i
//   i_done      current owner finished (only looked at while granting)
//   i_mode      0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   o_grant     registered one-hot grant, zero when idle
//   o_grant_id  winner bit index + 1, zero when idle
//   o_valid     a grant is active
//   o_timeout   one-cycle pulse after a hold-limit revoke
// ----------------------------------------------------------------------------
module req_arbiter_12 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [11:0] i_req,
   input  logic        i_done,
   input  logic        i_mode,
   output logic [11:0] o_grant,
   output logic [3:0]  o_grant_id,
   output logic        o_valid,
   output logic        o_timeout
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Last grant cycle index; a grant starts with the counter at 0.
   localparam logic       HOLD_EN   = (MAX_HOLD != 32'd0);
   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 32'd0) ? 8'd0 : 8'(MAX_HOLD - 32'd1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [11:0] r_grant;
   logic [11:0] w_grant_nxt;
   logic [3:0]  r_grant_id;
   logic [3:0]  w_grant_id_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_timeout;
   logic        w_timeout_nxt;
   logic [7:0]  r_hold;
   logic [7:0]  w_hold_nxt;
   logic [3:0]  r_ptr;
   logic [3:0]  w_ptr_nxt;

   logic        w_any_req;
   logic        w_owner_req;
   logic        w_hold_hit;
   logic [3:0]  w_win_fixed;
   logic [3:0]  w_win_rr;
   logic [3:0]  w_win;

   // Highest set bit wins (same as the 12-to-4 priority encoder).
   function automatic logic [3:0] pick_fixed(input logic [11:0] req);
      logic [3:0] win;
      win = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (req[i]) begin
            win = 4'(i);
         end
      end
      return win;
   endfunction

   // Walk downward from (ptr-1) mod 12; iterating from the far end lets the
   // nearest candidate overwrite the others.
   function automatic logic [3:0] pick_rr(input logic [11:0] req, input logic [3:0] ptr);
      logic [4:0] pos;
      logic [3:0] win;
      win = 4'd0;
      for (int k = 11; k >= 0; k--) begin
         pos = {1'b0, ptr} + 5'd11 - 5'(k);
         if (pos >= 5'd12) begin
            pos = pos - 5'd12;
         end
         if (req[pos[3:0]]) begin
            win = pos[3:0];
         end
      end
      return win;
   endfunction

   assign w_any_req   = |i_req;
   assign w_owner_req = |(i_req & r_grant);
   assign w_hold_hit  = HOLD_EN && (r_hold == HOLD_LAST);
   assign w_win_fixed = pick_fixed(i_req);
   assign w_win_rr    = pick_rr(i_req, r_ptr);
   assign w_win       = i_mode ? w_win_rr : w_win_fixed;

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_grant_id_nxt = r_grant_id;
      w_valid_nxt    = r_valid;
      w_timeout_nxt  = 1'b0;
      w_hold_nxt     = r_hold;
      w_ptr_nxt      = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt    = ST_GRANT;
               w_grant_nxt    = 12'd1 << w_win;
               w_grant_id_nxt = w_win + 4'd1;
               w_valid_nxt    = 1'b1;
               w_hold_nxt     = 8'd0;
               w_ptr_nxt      = w_win;
            end else begin
               w_state_nxt    = ST_IDLE;
               w_grant_nxt    = 12'd0;
               w_grant_id_nxt = 4'd0;
               w_valid_nxt    = 1'b0;
            end
         end
         ST_GRANT: begin
            // done and request drop take precedence over the hold limit,
            // so a coincident hold hit does not pulse timeout.
            if (i_done || !w_owner_req) begin
               w_state_nxt    = ST_IDLE;
               w_grant_nxt    = 12'd0;
               w_grant_id_nxt = 4'd0;
               w_valid_nxt    = 1'b0;
               w_hold_nxt     = 8'd0;
            end else if (w_hold_hit) begin
               w_state_nxt    = ST_IDLE;
               w_grant_nxt    = 12'd0;
               w_grant_id_nxt = 4'd0;
               w_valid_nxt    = 1'b0;
               w_hold_nxt     = 8'd0;
               w_timeout_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_GRANT;
               w_hold_nxt  = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_grant_nxt    = 12'd0;
            w_grant_id_nxt = 4'd0;
            w_valid_nxt    = 1'b0;
            w_hold_nxt     = 8'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_grant    <= 12'd0;
         r_grant_id <= 4'd0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
         r_hold     <= 8'd0;
         r_ptr      <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_valid    <= w_valid_nxt;
         r_timeout  <= w_timeout_nxt;
         r_hold     <= w_hold_nxt;
         r_ptr      <= w_ptr_nxt;
      end
   end

   assign o_grant    = r_grant;
   assign o_grant_id = r_grant_id;
   assign o_valid    = r_valid;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_req_arbiter_12.sv
// ----------------------------------------------------------------------------
// tb_req_arbiter_12
// Directed scenarios plus randomized traffic for req_arbiter_12, checked every
// cycle against a behavioural model (owner index, grant length, last winner).
// ----------------------------------------------------------------------------
module tb_req_arbiter_12;

   localparam int MAXH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] req;
   logic        done;
   logic        mode;
   logic [11:0] grant;
   logic [3:0]  grant_id;
   logic        valid;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int   m_owner = -1;   // granted bit index, -1 when idle
   int   m_held  = 0;    // grant cycles elapsed for current owner
   int   m_last  = 0;    // last winner index
   logic m_to    = 1'b0;

   always #5 clk = ~clk;

   req_arbiter_12 #(.MAX_HOLD(MAXH)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_req      (req),
      .i_done     (done),
      .i_mode     (mode),
      .o_grant    (grant),
      .o_grant_id (grant_id),
      .o_valid    (valid),
      .o_timeout  (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [11:0] r, input logic m, input int last);
      int b;
      if (!m) begin
         for (int i = 11; i >= 0; i--) if (r[i]) return i;
         return -1;
      end
      b = (last == 0) ? 11 : last - 1;
      for (int n = 0; n < 12; n++) begin
         if (r[b]) return b;
         b = (b == 0) ? 11 : b - 1;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      int w;
      if (reset) begin
         m_owner = -1; m_held = 0; m_last = 0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         w = pick(req, mode, m_last);
         if (w >= 0) begin
            m_owner = w; m_held = 1; m_last = w;
         end
      end else if (done || !req[m_owner]) begin
         m_owner = -1; m_to = 1'b0;
      end else if (MAXH != 0 && m_held >= MAXH) begin
         m_owner = -1; m_to = 1'b1;
      end else begin
         m_held++; m_to = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [11:0] eg;
      eg = (m_owner >= 0) ? (12'd1 << m_owner) : 12'd0;
      chk("grant",    32'(grant),    32'(eg));
      chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner + 1) : 32'd0);
      chk("valid",    32'(valid),    32'(m_owner >= 0));
      chk("timeout",  32'(timeout),  32'(m_to));
   endtask

   // One cycle: apply inputs (at a falling edge), step model, check at next falling edge.
   task automatic cyc(input logic [11:0] r, input logic d, input logic m, input logic rs);
      req = r; done = d; mode = m; reset = rs;
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int exp_id;
      int run;
      logic [11:0] rq;
      logic        md;

      req = 12'd0; done = 1'b0; mode = 1'b0; reset = 1'b1;
      cyc(12'd0, 1'b0, 1'b0, 1'b1);
      cyc(12'd0, 1'b0, 1'b0, 1'b1);
      cyc(12'd0, 1'b0, 1'b0, 1'b0);
      chk("reset_valid", 32'(valid), 32'd0);

      // fixed priority, two requesters, done on each grant cycle
      cyc(12'h801, 1'b1, 1'b0, 1'b0);
      chk("fix_grant_hi", 32'(grant), 32'h800);
      chk("fix_id_hi", 32'(grant_id), 32'd12);
      cyc(12'h001, 1'b1, 1'b0, 1'b0);
      chk("fix_gap", 32'(grant), 32'd0);
      cyc(12'h001, 1'b1, 1'b0, 1'b0);
      chk("fix_id_lo", 32'(grant_id), 32'd1);
      cyc(12'h000, 1'b0, 1'b0, 1'b0);

      // round-robin, all requesting, done held: 12,11,...,1,12
      exp_id = 12;
      for (int i = 0; i < 26; i++) begin
         cyc(12'hFFF, 1'b1, 1'b1, 1'b0);
         if (valid) begin
            chk("rr_seq", 32'(grant_id), 32'(exp_id));
            exp_id = (exp_id == 1) ? 12 : exp_id - 1;
         end
      end
      cyc(12'h000, 1'b0, 1'b0, 1'b0);
      cyc(12'h000, 1'b0, 1'b0, 1'b0);

      // hold limit on a single requester
      run = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(12'h080, 1'b0, 1'b0, 1'b0);
         if (valid) begin
            run++;
         end else begin
            if (timeout) chk("hold_len", 32'(run), 32'(MAXH));
            run = 0;
         end
      end
      cyc(12'h000, 1'b0, 1'b0, 1'b0);
      cyc(12'h000, 1'b0, 1'b0, 1'b0);

      // done on the last allowed grant cycle beats timeout
      for (int i = 0; i < MAXH; i++) cyc(12'h080, 1'b0, 1'b0, 1'b0);
      chk("hold_last_valid", 32'(valid), 32'd1);
      cyc(12'h080, 1'b1, 1'b0, 1'b0);
      chk("done_no_to", 32'(timeout), 32'd0);
      chk("done_drop", 32'(grant), 32'd0);

      // reset mid-grant, then round-robin restarts from bit 11
      cyc(12'h0C0, 1'b0, 1'b1, 1'b0);
      cyc(12'h0C0, 1'b0, 1'b1, 1'b0);
      cyc(12'h0C0, 1'b0, 1'b1, 1'b1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_id", 32'(grant_id), 32'd0);
      chk("rst_to", 32'(timeout), 32'd0);
      cyc(12'h0C0, 1'b0, 1'b1, 1'b0);
      chk("rst_rr_id", 32'(grant_id), 32'd8);
      cyc(12'h000, 1'b0, 1'b0, 1'b0);

      // request drop, then idle with no requests
      cyc(12'h0A0, 1'b0, 1'b0, 1'b0);
      chk("drop_id8", 32'(grant_id), 32'd8);
      cyc(12'h020, 1'b0, 1'b0, 1'b0);
      chk("drop_release", 32'(grant), 32'd0);
      cyc(12'h020, 1'b0, 1'b0, 1'b0);
      chk("drop_id6", 32'(grant_id), 32'd6);
      for (int i = 0; i < 6; i++) cyc(12'h000, 1'b0, 1'b0, 1'b0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_id", 32'(grant_id), 32'd0);

      // randomized traffic with persistent request lines
      rq = 12'd0;
      md = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 12; b++) begin
            if ($urandom_range(15, 0) == 0) rq[b] = ~rq[b];
         end
         if ($urandom_range(63, 0) == 0) md = ~md;
         cyc(rq, ($urandom_range(7, 0) == 0), md, ($urandom_range(199, 0) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
